// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared widths, entry layout and tag helpers for the reservation station
package reservation_station_pkg;

    localparam int RS_SIZE   = 16;
    localparam int RS_WIDTH  = 4;
    localparam int ROB_WIDTH = 4;
    localparam int OP_WIDTH  = 6;

    localparam logic [ROB_WIDTH-1:0] NO_DEP = '0;

    typedef struct packed {
        logic                 busy;
        logic [OP_WIDTH-1:0]  opcode;
        logic [ROB_WIDTH-1:0] qj;
        logic [ROB_WIDTH-1:0] qk;
        logic [31:0]          vj;
        logic [31:0]          vk;
        logic [31:0]          a;
        logic [ROB_WIDTH:0]   rob_id;
    } rs_entry_t;

    typedef struct packed {
        logic                valid;
        logic [OP_WIDTH-1:0] opcode;
        logic [31:0]         vj;
        logic [31:0]         vk;
        logic [31:0]         a;
        logic [ROB_WIDTH:0]  rob_id;
    } alu_issue_t;

    // Tag 0 never names a ROB entry, so it can never match a broadcast.
    function automatic logic tag_hit(input logic                 cdb_rdy,
                                     input logic [ROB_WIDTH-1:0] cdb_rob,
                                     input logic [ROB_WIDTH-1:0] tag);
        return cdb_rdy && (tag != NO_DEP) && (tag == cdb_rob);
    endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// rtl/rs_prio_enc.sv - lowest-index priority encoder returning index and found flag
module rs_prio_enc #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = i[W-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo reservation station between dispatcher and ALU
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,
    input  logic                 rdy_disp_in,
    input  logic [OP_WIDTH-1:0]  opcode_disp_in,
    input  logic [ROB_WIDTH-1:0] qj_disp_in,
    input  logic [ROB_WIDTH-1:0] qk_disp_in,
    input  logic [31:0]          vj_disp_in,
    input  logic [31:0]          vk_disp_in,
    input  logic [31:0]          A_disp_in,
    input  logic [ROB_WIDTH:0]   rob_id_disp_in,
    output logic                 full_out,
    input  logic                 cdb_rdy_in,
    input  logic [ROB_WIDTH-1:0] cdb_rob_in,
    input  logic [31:0]          cdb_val_in,
    output logic                 rdy_alu_out,
    output logic [OP_WIDTH-1:0]  opcode_alu_out,
    output logic [31:0]          vj_alu_out,
    output logic [31:0]          vk_alu_out,
    output logic [31:0]          A_alu_out,
    output logic [ROB_WIDTH:0]   rob_id_alu_out
);

    rs_entry_t [RS_SIZE-1:0] ent_q, ent_d;
    alu_issue_t              out_q, out_d;

    logic [RS_SIZE-1:0]  free_vec, ready_vec;
    logic [RS_WIDTH-1:0] free_idx, ready_idx;
    logic                free_found, ready_found;

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && (ent_q[i].qj == NO_DEP) && (ent_q[i].qk == NO_DEP);
        end
    end

    rs_prio_enc #(.N(RS_SIZE), .W(RS_WIDTH)) u_free_sel (
        .req_i   (free_vec),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    rs_prio_enc #(.N(RS_SIZE), .W(RS_WIDTH)) u_ready_sel (
        .req_i   (ready_vec),
        .idx_o   (ready_idx),
        .found_o (ready_found)
    );

    assign full_out = !free_found;

    // Wakeup, issue and dispatch all read pre-edge state; the free slot is
    // never the issuing slot because one is non-busy and the other busy.
    always_comb begin
        ent_d = ent_q;
        out_d = out_q;
        if (clr_in) begin
            for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
            out_d.valid = 1'b0;
        end else if (!rdy_in) begin
            out_d.valid = 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy && tag_hit(cdb_rdy_in, cdb_rob_in, ent_q[i].qj)) begin
                    ent_d[i].vj = cdb_val_in;
                    ent_d[i].qj = NO_DEP;
                end
                if (ent_q[i].busy && tag_hit(cdb_rdy_in, cdb_rob_in, ent_q[i].qk)) begin
                    ent_d[i].vk = cdb_val_in;
                    ent_d[i].qk = NO_DEP;
                end
            end
            out_d.valid = ready_found;
            if (ready_found) begin
                out_d.opcode          = ent_q[ready_idx].opcode;
                out_d.vj              = ent_q[ready_idx].vj;
                out_d.vk              = ent_q[ready_idx].vk;
                out_d.a               = ent_q[ready_idx].a;
                out_d.rob_id          = ent_q[ready_idx].rob_id;
                ent_d[ready_idx].busy = 1'b0;
            end
            if (rdy_disp_in && free_found) begin
                ent_d[free_idx].busy   = 1'b1;
                ent_d[free_idx].opcode = opcode_disp_in;
                ent_d[free_idx].a      = A_disp_in;
                ent_d[free_idx].rob_id = rob_id_disp_in;
                if (tag_hit(cdb_rdy_in, cdb_rob_in, qj_disp_in)) begin
                    ent_d[free_idx].qj = NO_DEP;
                    ent_d[free_idx].vj = cdb_val_in;
                end else begin
                    ent_d[free_idx].qj = qj_disp_in;
                    ent_d[free_idx].vj = vj_disp_in;
                end
                if (tag_hit(cdb_rdy_in, cdb_rob_in, qk_disp_in)) begin
                    ent_d[free_idx].qk = NO_DEP;
                    ent_d[free_idx].vk = cdb_val_in;
                end else begin
                    ent_d[free_idx].qk = qk_disp_in;
                    ent_d[free_idx].vk = vk_disp_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            ent_q <= '0;
            out_q <= '0;
        end else begin
            ent_q <= ent_d;
            out_q <= out_d;
        end
    end

    assign rdy_alu_out    = out_q.valid;
    assign opcode_alu_out = out_q.opcode;
    assign vj_alu_out     = out_q.vj;
    assign vk_alu_out     = out_q.vk;
    assign A_alu_out      = out_q.a;
    assign rob_id_alu_out = out_q.rob_id;

endmodule
